move_stack_arbiter: RTL and testbench
=====================================

Name: move_stack_arbiter

Overview:
Clocked LIFO of ant moves (3-bit direction codes), shared between several ant controllers through a round-robin arbiter. Each requester issues push (record a move) or pop (backtrack one move). The block serialises these into one stack operation at a time and returns a per-operation response. It sits between the ant movement FSMs and the move history storage.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 3, move width in bits
DEPTH, 32, stack depth in moves
CW, $clog2(DEPTH+1), count width (derived, localparam)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
req_valid  input  NREQ  per-requester request pending
req_op  input  NREQ  per-requester op: 1=push, 0=pop
req_move  input  NREQ*W  per-requester push data; requester i uses bits [i*W+W-1:i*W]
req_ready  output  NREQ  one-hot grant pulse
flush  input  1  clear the stack
rsp_valid  output  1  response strobe, one cycle
rsp_id  output  $clog2(NREQ)  index of the served requester
rsp_move  output  W  pushed move (push) or popped move (pop); 0 on error
rsp_err  output  1  push while full or pop while empty
count  output  CW  current occupancy
full  output  1  count==DEPTH
empty  output  1  count==0

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=NREQ-1, count=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_move=0, rsp_err=0. Storage array is not reset. Any in-flight request is dropped with no response.
- FSM: IDLE -> EXEC -> RESP -> IDLE. One operation every 3 cycles.
- IDLE:
  - flush=1 has priority. count<=0, no grant, stay in IDLE.
  - Otherwise, if any req_valid is set, pick the winner. The search starts at (rr_ptr+1) mod NREQ and goes upward with wrap. Latch the winner's id, op and move. rr_ptr<=winner. Go to EXEC.
  - First grant after reset goes to requester 0.
- EXEC:
  - req_ready[winner]=1 for this cycle only; it is a registered output.
  - Push, count<DEPTH: mem[count]<=move, count<=count+1.
  - Pop, count>0: rsp_move<=mem[count-1], count<=count-1.
  - Error cases leave the stack unchanged, with rsp_err<=1 and rsp_move<=0.
  - rsp_id is loaded. Go to RESP.
- RESP: rsp_valid=1 for one cycle; rsp_id, rsp_move and rsp_err hold until the next RESP. Go to IDLE.
- Requester protocol:
  - Hold req_valid, req_op and req_move stable until req_ready is seen.
  - Deassert req_valid on the edge that ends the EXEC cycle.
  - A requester still asserting in IDLE after its RESP is treated as a new request.
- flush in EXEC or RESP is ignored; flush is sampled only in IDLE.
- full and empty are combinational from count. count never exceeds DEPTH and never underflows.
- req_valid bits for a non-winner are unaffected by grants. Those requesters wait; starvation is bounded to NREQ-1 operations.

Optional Feature:
Macro REVERSE_ON_POP_EN.
- Defined: a successful pop returns the opposite direction, rsp_move = mem[count-1] ^ {1'b1,{(W-1){1'b0}}} (MSB inverted). This lets an ant backtrack by executing rsp_move directly. Push responses and error responses (0) are unchanged.
- Undefined: pop returns the stored move unmodified.

Test Plan:
- Reset check: assert rst mid-EXEC -> next cycle count=0, req_ready=0, rsp_valid=0, empty=1, no RESP for the dropped request.
- Basic push/pop: req0 pushes 3'd5 -> req_ready[0] in cycle 2, rsp_valid in cycle 3 with rsp_move=5, count=1. req0 then pops -> rsp_move=5 (3'd1 with REVERSE_ON_POP_EN), count=0, empty=1.
- Overflow: 32 pushes of values i mod 8 -> full=1, count=32. The 33rd push gives rsp_err=1, rsp_move=0, count stays 32. Then 32 pops return values in reverse order 7,6,...
- Underflow: pop on an empty stack -> rsp_err=1, rsp_move=0, count=0.
- Round-robin: req 0, 2 and 3 held valid from reset -> grants in order 0, 2, 3, 0. rsp_id follows the same order, with 3 cycles per grant.
- Flush priority: count=4 and flush=1 together with req1 valid in IDLE -> count=0 with no grant that cycle. req1 is granted on the following IDLE cycle; flush asserted during EXEC is ignored.

Source files
------------

// File: rtl/move_stack_arbiter.sv
// Round-robin arbitrated LIFO of ant moves: one push/pop served every three cycles.
// Optional macro REVERSE_ON_POP_EN: successful pops return the move with its MSB inverted.
`timescale 1ns/1ps
module move_stack_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned W     = 3,
    parameter int unsigned DEPTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ-1:0]              req_op,
    input  logic [NREQ*W-1:0]            req_move,
    output logic [NREQ-1:0]              req_ready,
    input  logic                         flush,
    output logic                         rsp_valid,
    output logic [$clog2(NREQ)-1:0]      rsp_id,
    output logic [W-1:0]                 rsp_move,
    output logic                         rsp_err,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned SW  = IDW + 1;
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   win_id_q, win_id_d;
    logic             win_op_q, win_op_d;
    logic [W-1:0]     win_move_q, win_move_d;
    logic [CW-1:0]    count_d;
    logic [NREQ-1:0]  req_ready_d;
    logic             rsp_valid_d;
    logic [IDW-1:0]   rsp_id_d;
    logic [W-1:0]     rsp_move_d;
    logic             rsp_err_d;

    logic [W-1:0]     mem [DEPTH];
    logic             mem_we;
    logic [AW-1:0]    rd_addr;
    logic [W-1:0]     pop_move;

    logic             found;
    logic [IDW-1:0]   pick;
    logic [SW-1:0]    sum;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_addr = AW'(count - CW'(1));

`ifdef REVERSE_ON_POP_EN
    assign pop_move = mem[rd_addr] ^ (W'(1) << (W - 1));
`else
    assign pop_move = mem[rd_addr];
`endif

    // Round-robin search starting just after the last winner, wrapping at NREQ
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            sum = SW'(rr_ptr_q) + SW'(k);
            if (sum >= SW'(NREQ)) begin
                sum = sum - SW'(NREQ);
            end
            if (!found && req_valid[sum[IDW-1:0]]) begin
                found = 1'b1;
                pick  = sum[IDW-1:0];
            end
        end
    end

    // Next-state and registered-output values
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_id_d    = win_id_q;
        win_op_d    = win_op_q;
        win_move_d  = win_move_q;
        count_d     = count;
        req_ready_d = '0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id;
        rsp_move_d  = rsp_move;
        rsp_err_d   = rsp_err;
        mem_we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    count_d = '0;
                end else if (found) begin
                    win_id_d          = pick;
                    win_op_d          = req_op[pick];
                    win_move_d        = req_move[pick*W +: W];
                    rr_ptr_d          = pick;
                    req_ready_d[pick] = 1'b1;
                    state_d           = EXEC;
                end
            end
            EXEC: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = win_id_q;
                rsp_err_d   = 1'b0;
                state_d     = RESP;
                if (win_op_q) begin
                    if (!full) begin
                        mem_we     = 1'b1;
                        count_d    = count + CW'(1);
                        rsp_move_d = win_move_q;
                    end else begin
                        rsp_err_d  = 1'b1;
                        rsp_move_d = '0;
                    end
                end else begin
                    if (!empty) begin
                        count_d    = count - CW'(1);
                        rsp_move_d = pop_move;
                    end else begin
                        rsp_err_d  = 1'b1;
                        rsp_move_d = '0;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= IDW'(NREQ - 1);
            win_id_q   <= '0;
            win_op_q   <= 1'b0;
            win_move_q <= '0;
            count      <= '0;
            req_ready  <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_move   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            win_id_q   <= win_id_d;
            win_op_q   <= win_op_d;
            win_move_q <= win_move_d;
            count      <= count_d;
            req_ready  <= req_ready_d;
            rsp_valid  <= rsp_valid_d;
            rsp_id     <= rsp_id_d;
            rsp_move   <= rsp_move_d;
            rsp_err    <= rsp_err_d;
        end
    end

    // Move storage is intentionally left unreset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[AW'(count)] <= win_move_q;
        end
    end

endmodule

// File: tb/tb_move_stack_arbiter.sv
// Directed, table-driven bench for move_stack_arbiter (default parameters).
`timescale 1ns/1ps
module tb_move_stack_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned W     = 3;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned CW    = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_op;
    logic [NREQ*W-1:0] req_move;
    logic [NREQ-1:0]   req_ready;
    logic              flush;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_move;
    logic              rsp_err;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;

    int n_chk  = 0;
    int n_fail = 0;

    move_stack_arbiter #(.NREQ(NREQ), .W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_move  (req_move),
        .req_ready (req_ready),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_move  (rsp_move),
        .rsp_err   (rsp_err),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        int         id;
        logic       op;
        logic [2:0] mv;
        logic [2:0] exp_mv;
        logic       exp_err;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [2:0] rev(input logic [2:0] v);
`ifdef REVERSE_ON_POP_EN
        return v ^ 3'b100;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one request at a negedge; returns at the negedge inside RESP
    task automatic do_op(input int id, input logic op, input logic [2:0] mv,
                         output logic [2:0] got_mv, output logic got_err);
        int n;
        req_valid[id]          = 1'b1;
        req_op[id]             = op;
        req_move[id*W +: W]    = mv;
        n = 0;
        @(negedge clk);
        while (!req_ready[id] && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[id]) begin
            chk("grant_timeout", 0, 1);
            req_valid[id] = 1'b0;
            got_mv  = '0;
            got_err = 1'b1;
            return;
        end
        req_valid[id] = 1'b0;
        @(negedge clk);
        chk("op_rsp_valid", int'(rsp_valid), 1);
        chk("op_rsp_id", int'(rsp_id), id);
        got_mv  = rsp_move;
        got_err = rsp_err;
    endtask

    initial begin
        logic [2:0] gm;
        logic       ge;
        int         n;
        int         exp_id[4];
        logic       seen;

        vecs[0] = '{0, 1'b0, 3'd0, rev(3'd5), 1'b0, 0};
        vecs[1] = '{0, 1'b0, 3'd0, 3'd0,      1'b1, 0};
        vecs[2] = '{1, 1'b1, 3'd3, 3'd3,      1'b0, 1};
        vecs[3] = '{2, 1'b1, 3'd6, 3'd6,      1'b0, 2};
        vecs[4] = '{3, 1'b1, 3'd0, 3'd0,      1'b0, 3};
        vecs[5] = '{1, 1'b0, 3'd0, rev(3'd0), 1'b0, 2};
        vecs[6] = '{0, 1'b0, 3'd0, rev(3'd6), 1'b0, 1};
        vecs[7] = '{3, 1'b0, 3'd0, rev(3'd3), 1'b0, 0};
        vecs[8] = '{2, 1'b0, 3'd0, 3'd0,      1'b1, 0};

        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_move  = '0;
        flush     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_rsp_move", int'(rsp_move), 0);
        chk("rst_rsp_err", int'(rsp_err), 0);
        rst = 1'b0;

        // Basic push: grant in cycle 2, response in cycle 3
        req_valid[0] = 1'b1;
        req_op[0]    = 1'b1;
        req_move[2:0] = 3'd5;
        @(negedge clk);
        chk("basic_grant", int'(req_ready), 1);
        chk("basic_no_rsp_yet", int'(rsp_valid), 0);
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("basic_rsp_valid", int'(rsp_valid), 1);
        chk("basic_rsp_move", int'(rsp_move), 5);
        chk("basic_rsp_err", int'(rsp_err), 0);
        chk("basic_count", int'(count), 1);
        @(negedge clk);
        chk("basic_rsp_pulse", int'(rsp_valid), 0);
        chk("basic_rsp_hold", int'(rsp_move), 5);

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].id, vecs[i].op, vecs[i].mv, gm, ge);
            chk($sformatf("vec%0d_move", i), int'(gm), int'(vecs[i].exp_mv));
            chk($sformatf("vec%0d_err", i), int'(ge), int'(vecs[i].exp_err));
            chk($sformatf("vec%0d_count", i), int'(count), vecs[i].exp_cnt);
            chk($sformatf("vec%0d_empty", i), int'(empty), (vecs[i].exp_cnt == 0) ? 1 : 0);
        end

        // Fill to capacity, overflow, then drain in reverse order
        for (int i = 0; i < 32; i++) begin
            do_op(0, 1'b1, 3'(i % 8), gm, ge);
            chk($sformatf("fill%0d_count", i), int'(count), i + 1);
        end
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 32);
        do_op(0, 1'b1, 3'd6, gm, ge);
        chk("ovf_err", int'(ge), 1);
        chk("ovf_move", int'(gm), 0);
        chk("ovf_count", int'(count), 32);
        for (int i = 0; i < 32; i++) begin
            do_op(2, 1'b0, 3'd0, gm, ge);
            chk($sformatf("drain%0d_move", i), int'(gm), int'(rev(3'((31 - i) % 8))));
            chk($sformatf("drain%0d_err", i), int'(ge), 0);
        end
        chk("drain_count", int'(count), 0);
        chk("drain_empty", int'(empty), 1);
        chk("drain_full", int'(full), 0);

        // Reset asserted while a push is in EXEC
        do_op(0, 1'b1, 3'd2, gm, ge);
        chk("pre_rst_count", int'(count), 1);
        req_valid[0] = 1'b1;
        req_op[0]    = 1'b1;
        req_move[2:0] = 3'd4;
        n = 0;
        @(negedge clk);
        while (!req_ready[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("midexec_grant", int'(req_ready[0]), 1);
        rst = 1'b1;
        #1;
        chk("midexec_rst_count", int'(count), 0);
        chk("midexec_rst_ready", int'(req_ready), 0);
        chk("midexec_rst_rsp", int'(rsp_valid), 0);
        chk("midexec_rst_empty", int'(empty), 1);
        req_valid = '0;
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("midexec_no_rsp", int'(seen), 0);
        chk("midexec_count_after", int'(count), 0);

        // Round-robin among requesters 0, 2, 3 held valid from reset
        rst       = 1'b1;
        req_valid = 4'b1101;
        req_op    = 4'b1111;
        req_move  = {3'd7, 3'd6, 3'd5, 3'd4};
        @(negedge clk);
        rst = 1'b0;
        exp_id = '{0, 2, 3, 0};
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (req_ready == '0 && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("rr%0d_grant", g), int'(req_ready), 1 << exp_id[g]);
            if (g > 0) chk($sformatf("rr%0d_gap", g), n, 2);
            if (g == 3) req_valid = '0;
            @(negedge clk);
            chk($sformatf("rr%0d_rsp_id", g), int'(rsp_id), exp_id[g]);
        end
        chk("rr_count", int'(count), 4);

        // Flush in IDLE beats a pending request; flush in EXEC is ignored
        flush        = 1'b1;
        req_valid[1] = 1'b1;
        req_op[1]    = 1'b1;
        req_move[5:3] = 3'd1;
        @(negedge clk);
        chk("flush_pre_count", int'(count), 4);
        chk("flush_pre_ready", int'(req_ready), 0);
        @(negedge clk);
        chk("flush_count", int'(count), 0);
        chk("flush_no_grant", int'(req_ready), 0);
        chk("flush_empty", int'(empty), 1);
        flush = 1'b0;
        @(negedge clk);
        chk("flush_then_grant", int'(req_ready), 2);
        flush        = 1'b1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("flush_exec_rsp", int'(rsp_valid), 1);
        chk("flush_exec_id", int'(rsp_id), 1);
        chk("flush_exec_count", int'(count), 1);
        flush = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
